// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register sitting directly behind the PC register.
// Captures the fetched instruction and its PC, flags fetch address errors
// (AdEL), tags branch-delay-slot instructions, and supports stall, flush and
// exception-entry clear. All outputs come straight from flops.
//
// Optional feature macro: IF_ID_STALL_CNT_EN
//   defined   -> stall_cnt counts stalled edges (saturating, reset-only clear)
//   undefined -> stall_cnt is tied to zero and no counter flops exist
module if_id_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic        req,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exccode_d,
  output logic        bd_d,
  output logic        valid_d,
  output logic [31:0] stall_cnt
);

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] LINK_OFS = 32'd8;

  // Fetch address is illegal when misaligned or outside instruction memory.
  function automatic logic fetch_addr_err(input logic [31:0] pc);
    logic err;
    err = 1'b0;
    if (pc[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (pc < IMEM_LO) begin
      err = 1'b1;
    end else if (pc > IMEM_HI) begin
      err = 1'b1;
    end else begin
      err = 1'b0;
    end
    return err;
  endfunction

  // True when the instruction changes control flow, so the next one is a delay slot.
  function automatic logic is_branch(input logic [31:0] ins);
    logic br;
    br = 1'b0;
    case (ins[31:26])
      6'b000100: br = 1'b1; // beq
      6'b000101: br = 1'b1; // bne
      6'b000110: br = 1'b1; // blez
      6'b000111: br = 1'b1; // bgtz
      6'b000001: br = 1'b1; // regimm (bltz/bgez/...)
      6'b000010: br = 1'b1; // j
      6'b000011: br = 1'b1; // jal
      6'b000000: begin
        case (ins[5:0])
          6'b001000: br = 1'b1; // jr
          6'b001001: br = 1'b1; // jalr
          default:   br = 1'b0;
        endcase
      end
      default: br = 1'b0;
    endcase
    return br;
  endfunction

  logic [31:0] instr_q, instr_nx_d;
  logic [31:0] pc_q,    pc_nx_d;
  logic [31:0] pc8_q,   pc8_nx_d;
  logic [4:0]  exc_q,   exc_nx_d;
  logic        bd_q,    bd_nx_d;
  logic        valid_q, valid_nx_d;
  logic        addr_err_s;
  logic        prev_br_s;

  assign addr_err_s = fetch_addr_err(pc_f);
  assign prev_br_s  = is_branch(instr_q) & valid_q;

  // Next-state selection: req > stall (hold) > flush > normal load.
  always_comb begin
    instr_nx_d = instr_q;
    pc_nx_d    = pc_q;
    pc8_nx_d   = pc8_q;
    exc_nx_d   = exc_q;
    bd_nx_d    = bd_q;
    valid_nx_d = valid_q;
    if (req) begin
      instr_nx_d = 32'h0000_0000;
      pc_nx_d    = HANDLER_PC;
      pc8_nx_d   = HANDLER_PC + LINK_OFS;
      exc_nx_d   = EXC_NONE;
      bd_nx_d    = 1'b0;
      valid_nx_d = 1'b0;
    end else if (!en) begin
      // stalled: hold everything, flush request ignored
      instr_nx_d = instr_q;
      pc_nx_d    = pc_q;
      pc8_nx_d   = pc8_q;
      exc_nx_d   = exc_q;
      bd_nx_d    = bd_q;
      valid_nx_d = valid_q;
    end else if (clr) begin
      instr_nx_d = 32'h0000_0000;
      pc_nx_d    = pc_f;
      pc8_nx_d   = pc_f + LINK_OFS;
      exc_nx_d   = EXC_NONE;
      bd_nx_d    = 1'b0;
      valid_nx_d = 1'b0;
    end else begin
      pc_nx_d    = pc_f;
      pc8_nx_d   = pc_f + LINK_OFS;
      bd_nx_d    = prev_br_s;
      valid_nx_d = 1'b1;
      if (addr_err_s) begin
        instr_nx_d = 32'h0000_0000;
        exc_nx_d   = EXC_ADEL;
      end else begin
        instr_nx_d = instr_f;
        exc_nx_d   = EXC_NONE;
      end
    end
  end

  // D-stage state register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'h0000_0000;
      pc_q    <= RESET_PC;
      pc8_q   <= RESET_PC + LINK_OFS;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_nx_d;
      pc_q    <= pc_nx_d;
      pc8_q   <= pc8_nx_d;
      exc_q   <= exc_nx_d;
      bd_q    <= bd_nx_d;
      valid_q <= valid_nx_d;
    end
  end

  assign instr_d   = instr_q;
  assign pc_d      = pc_q;
  assign pc8_d     = pc8_q;
  assign exccode_d = exc_q;
  assign bd_d      = bd_q;
  assign valid_d   = valid_q;

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Stall counter next value: count edges with en low and no exception entry, saturating.
  always_comb begin
    stall_d = stall_q;
    if (!en && !req && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 32'h0000_0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg.
module tb_if_id_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic        req;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic [4:0]  exccode_d;
  logic        bd_d;
  logic        valid_d;
  logic [31:0] stall_cnt;

  int n_cmp;
  int n_bad;

  if_id_reg dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .req       (req),
    .pc_f      (pc_f),
    .instr_f   (instr_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .exccode_d (exccode_d),
    .bd_d      (bd_d),
    .valid_d   (valid_d),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and sample shortly after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic r,
                       input logic [31:0] pc, input logic [31:0] ins);
    en = e; clr = c; req = r; pc_f = pc; instr_f = ins;
  endtask

  logic [31:0] exp_stall;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_instr", instr_d, 32'h0);
    check("rst_pc",    pc_d,    32'h0000_3000);
    check("rst_pc8",   pc8_d,   32'h0000_3008);
    check("rst_exc",   {27'd0, exccode_d}, 32'd0);
    check("rst_bd",    {31'd0, bd_d},      32'd0);
    check("rst_valid", {31'd0, valid_d},   32'd0);
    check("rst_stall", stall_cnt, 32'd0);

    // release reset away from the edge
    @(negedge clk);
    reset = 1'b0;

    // first load
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h3C01_1234);
    tick();
    check("ld0_instr", instr_d, 32'h3C01_1234);
    check("ld0_pc",    pc_d,    32'h0000_3000);
    check("ld0_pc8",   pc8_d,   32'h0000_3008);
    check("ld0_valid", {31'd0, valid_d}, 32'd1);
    check("ld0_exc",   {27'd0, exccode_d}, 32'd0);
    check("ld0_bd",    {31'd0, bd_d}, 32'd0);

    // beq, then delay slot, then ordinary instruction
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h1022_0003);
    tick();
    check("beq_instr", instr_d, 32'h1022_0003);
    check("beq_bd",    {31'd0, bd_d}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3008, 32'h0000_0020);
    tick();
    check("slot_bd",    {31'd0, bd_d}, 32'd1);
    check("slot_instr", instr_d, 32'h0000_0020);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_300C, 32'h0000_0020);
    tick();
    check("post_bd",   {31'd0, bd_d}, 32'd0);

    // jr at 0x3010-ish: opcode 0 funct 001000 -> next is delay slot
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h03E0_0008);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3014, 32'h0000_0020);
    tick();
    check("jr_bd", {31'd0, bd_d}, 32'd1);

    // address errors
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3002, 32'h2442_0001);
    tick();
    check("mis_exc",   {27'd0, exccode_d}, 32'd4);
    check("mis_instr", instr_d, 32'h0);
    check("mis_valid", {31'd0, valid_d}, 32'd1);
    check("mis_pc8",   pc8_d, 32'h0000_300A);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h2442_0001);
    tick();
    check("hi_exc", {27'd0, exccode_d}, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_6FFC, 32'h2442_0001);
    tick();
    check("top_exc",   {27'd0, exccode_d}, 32'd0);
    check("top_instr", instr_d, 32'h2442_0001);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_2FFC, 32'h2442_0001);
    tick();
    check("lo_exc", {27'd0, exccode_d}, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h2442_0001);
    tick();
    check("wrap_pc8", pc8_d, 32'h0000_0004);
    check("wrap_exc", {27'd0, exccode_d}, 32'd4);

    // hold at 0x3010
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3010, 32'h0000_0020);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3100, 32'h1111_1111);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3200, 32'h2222_2222);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_3300, 32'h3333_3333);
    tick();
    check("hold_pc",    pc_d, 32'h0000_3010);
    check("hold_pc8",   pc8_d, 32'h0000_3018);
    check("hold_instr", instr_d, 32'h0000_0020);
    check("hold_valid", {31'd0, valid_d}, 32'd1);
`ifdef IF_ID_STALL_CNT_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check("hold_stall", stall_cnt, exp_stall);

    // flush
    drive(1'b1, 1'b1, 1'b0, 32'h0000_3020, 32'h2442_0001);
    tick();
    check("fl_instr", instr_d, 32'h0);
    check("fl_pc",    pc_d, 32'h0000_3020);
    check("fl_pc8",   pc8_d, 32'h0000_3028);
    check("fl_valid", {31'd0, valid_d}, 32'd0);

    // flush plus exception entry
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3020, 32'h2442_0001);
    tick();
    check("rq_pc",    pc_d, 32'h0000_4180);
    check("rq_pc8",   pc8_d, 32'h0000_4188);
    check("rq_valid", {31'd0, valid_d}, 32'd0);

    // exception entry overrides stall and does not count as a stall
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3030, 32'h1000_0001);
    tick();
    check("pre_rq_pc", pc_d, 32'h0000_3030);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_3034, 32'h2442_0001);
    tick();
    check("rqst_pc",    pc_d, 32'h0000_4180);
    check("rqst_instr", instr_d, 32'h0);
    check("rqst_bd",    {31'd0, bd_d}, 32'd0);
    check("rqst_stall", stall_cnt, exp_stall);

    // asynchronous reset mid-cycle
    drive(1'b1, 1'b0, 1'b0, 32'h0000_3040, 32'h2442_0001);
    tick();
    check("pre_ar_pc", pc_d, 32'h0000_3040);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pc",    pc_d, 32'h0000_3000);
    check("ar_pc8",   pc8_d, 32'h0000_3008);
    check("ar_instr", instr_d, 32'h0);
    check("ar_valid", {31'd0, valid_d}, 32'd0);
    check("ar_stall", stall_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register directly downstream of the PC register.
- Captures the fetched instruction and its PC each cycle.
- Detects fetch address errors and tags branch-delay-slot instructions for CP0.
- Supports stall (hold), flush (bubble) and exception-entry clear.

Parameters:
- RESET_PC, 32'h00003000, PC value presented in D after reset.
- HANDLER_PC, 32'h00004180, PC value loaded on exception entry.
- IMEM_LO, 32'h00003000, lowest legal fetch address.
- IMEM_HI, 32'h00006FFC, highest legal fetch address.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  load enable; 0 = stall (hold all state).
- clr  input  1  flush: load a bubble instead of the F-stage instruction.
- req  input  1  exception/interrupt entry: clear stage, PC := HANDLER_PC.
- pc_f  input  32  F-stage PC (PC register output).
- instr_f  input  32  instruction read at pc_f.
- instr_d  output  32  D-stage instruction.
- pc_d  output  32  D-stage PC.
- pc8_d  output  32  pc_d + 8 (link address).
- exccode_d  output  5  fetch exception code; 0 = none, 4 = AdEL.
- bd_d  output  1  D-stage instruction sits in a branch delay slot.
- valid_d  output  1  D stage holds a real (non-bubble) instruction.
- stall_cnt  output  32  stall cycle counter (see Optional Feature).

Behaviour:
- Reset (async, immediate, any phase):
  - instr_d=0, pc_d=RESET_PC, pc8_d=RESET_PC+8, exccode_d=0, bd_d=0, valid_d=0, stall_cnt=0.
- Per-edge priority, highest first: reset > req > !en (hold) > clr > load.
- req=1:
  - instr_d=0, pc_d=HANDLER_PC, pc8_d=HANDLER_PC+8, exccode_d=0, bd_d=0, valid_d=0.
  - Overrides en=0 and clr.
- en=0 (req=0): all outputs hold; clr is ignored while stalled.
- clr=1, en=1:
  - instr_d=0, pc_d=pc_f, pc8_d=pc_f+8, exccode_d=0, valid_d=0.
  - bd_d=0.
- Load (en=1, clr=0, req=0): pc_d=pc_f, pc8_d=pc_f+8, valid_d=1.
  - Address error when pc_f[1:0]!=0, pc_f<IMEM_LO, or pc_f>IMEM_HI: exccode_d=4 and instr_d=0 (nop).
  - Otherwise exccode_d=0 and instr_d=instr_f.
  - bd_d = 1 iff current instr_d (the previous D instruction) is a branch/jump and current valid_d=1.
  - Branch/jump opcodes: beq 000100, bne 000101, blez 000110, bgtz 000111, regimm 000001, j 000010, jal 000011; opcode 000000 with funct 001000 (jr) or 001001 (jalr).
- Arithmetic: pc8_d is a 32-bit add; it wraps modulo 2^32 and has no carry out.
- Latency: one cycle from F inputs to D outputs.
- Outputs are purely registered; there is no combinational path from input to output.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - stall_cnt increments on every edge with en=0, req=0, reset=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by reset.
- Undefined: stall_cnt is constant 0 and no counter register is inferred.

Test Plan:
- Reset then release; first edge with en=1, pc_f=0x3000, instr_f=0x3C011234 -> instr_d=0x3C011234, pc_d=0x3000, pc8_d=0x3008, valid_d=1, exccode_d=0, bd_d=0.
- Load beq (0x10220003) at 0x3004, then instr_f=0x00000020 at 0x3008 -> second load gives bd_d=1. Then a non-branch at 0x300C -> bd_d=0.
- Address errors:
  - pc_f=0x3002 -> exccode_d=4, instr_d=0, valid_d=1.
  - pc_f=0x7000 -> exccode_d=4.
  - pc_f=0x6FFC -> exccode_d=0.
- Hold D at pc_d=0x3010, then 3 cycles en=0 with clr=1 and changing pc_f -> outputs unchanged. With macro defined, stall_cnt=3.
- en=1, clr=1, pc_f=0x3020 -> instr_d=0, pc_d=0x3020, valid_d=0. Same cycle with req=1 -> pc_d=0x4180, pc8_d=0x4188, valid_d=0.
- Assert reset asynchronously mid-cycle while pc_d=0x3040 -> outputs return to reset values before the next clk edge.
